wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Parametrised weighted round-robin arbiter for the CPU bus fabric. It grants one of NUM_REQ requesters at a time and holds the grant until the winner acknowledges a transfer. A granted requester may keep the bus for up to weight+1 consecutive transfers. A fixed-priority mode is selectable at run time. Upstream it sits between the requesting masters (fetch, load/store, DMA, debug) and the shared memory port, and it drives the port mux select from grant_idx.

## Interface
Parameters:
- NUM_REQ, 5, number of requesters (2..32)
- WEIGHT_W, 4, width of each per-requester weight field
- IDX_W, $clog2(NUM_REQ), width of grant_idx

Ports (reset rst, synchronous, active-high; clock clk):
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  request vector, bit i = requester i
- ack  input  1  granted requester completed one transfer this cycle
- weight  input  NUM_REQ*WEIGHT_W  field i = weight[i*WEIGHT_W +: WEIGHT_W]; extra transfers allowed for requester i
- mode  input  1  0 = weighted round-robin, 1 = fixed priority (index 0 highest)
- grant  output  NUM_REQ  registered one-hot grant, all-zero when idle
- grant_valid  output  1  OR of grant
- grant_idx  output  IDX_W  binary index of granted requester, 0 when idle

## Operation
- State: grant register, idx, credit counter (WEIGHT_W bits), and round-robin pointer ptr (IDX_W bits, range 0..NUM_REQ-1).
- Arbitration function: search req starting at ptr (mode 0) or at 0 (mode 1), ascending with wrap past NUM_REQ-1 to 0. The first set bit wins. There is no winner if req is all-zero.
- IDLE (grant_valid=0): arbitrate every cycle. On a winner w, the next cycle loads grant=1<<w, grant_idx=w, and credit=weight[w]. weight is sampled only at grant time.
- GRANTED, ack=1 and req[idx]=1 and credit!=0: keep the grant and decrement credit.
- GRANTED, ack=1 and (credit==0 or req[idx]=0): release. Set ptr=(idx+1) mod NUM_REQ. Re-arbitrate in the same cycle using the new ptr and the current req. This gives back-to-back grants with no idle bubble. The released requester may win again only if no other requester is pending.
- GRANTED, ack=0 and req[idx]=0: withdraw the grant. Release and advance ptr exactly as for a release on ack.
- GRANTED, ack=0 and req[idx]=1: hold all state.
- In mode 1, ptr is still updated on release but is ignored for the search. Weights still apply.
- A mode change takes effect at the next arbitration and does not preempt a current grant.
- ack while idle is ignored.
- Invariants: grant is always one-hot or zero. grant_idx is consistent with grant.

## Timing
- Reset: grant=0, grant_valid=0, grant_idx=0, ptr=0, credit=0. rst overrides every other input in the same cycle. Asserting rst mid-grant drops the grant on the next edge.
- Latency from req (idle) to grant: 1 clock. There is no combinational path from req or ack to grant.
- Handover on release: the new grant appears on the edge following the ack edge, which is 0 idle cycles.
- Maximum tenure: weight[i]+1 acks. Worst-case wait in mode 0 is the sum over the other requesters of (weight+1) transfers.
- Pointer wrap: idx=NUM_REQ-1 releases to ptr=0.
- Weight arithmetic: credit is unsigned and never underflows, because decrement happens only when credit!=0.

## Test plan
All scenarios use NUM_REQ=5, WEIGHT_W=4.
- Reset and idle: assert rst 2 cycles with req=5'b11111 -> grant=0, grant_idx=0 during reset. One cycle after release, grant=5'b00001.
- Round-robin rotation: all weights 0, req=5'b11111, ack every cycle -> grant_idx sequence 0,1,2,3,4,0 with no gap cycles.
- Weighted tenure: weight[1]=2, others 0, req=5'b00110, ack every cycle -> grant_idx 1,1,1,2,1,1,1,2.
- Early drop: requester 3 granted with weight 7; deassert req[3] with ack=0 -> grant moves to the next pending requester (e.g. 4) on the next edge, and ptr=4.
- Fixed priority: mode=1, weights 0, req=5'b10100, ack each cycle -> grant_idx 2,2,2. Then drop req[2] -> grant_idx 4.
- Mid-operation reset and wrap: grant on idx 4, pulse rst during a held grant -> grant=0 the next cycle. After reset, with req=5'b10001, the first grant is idx 0. After the ack, the grant is idx 4. After the next ack, the grant wraps to idx 0.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
// Bus-side signal bundle of the weighted round-robin arbiter.
//
// Handshake: a requester holds its req bit high for as long as it wants the
// bus. The arbiter answers with a registered one-hot grant. While a grant is
// up, ack=1 marks one completed transfer by the granted requester in that
// cycle. Dropping req of the granted requester withdraws the grant whether
// or not ack is high. ack is ignored while no grant is up.
interface wrr_arbiter_if #(
  parameter int NUM_REQ  = 5,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req;
  logic                        ack;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic                        mode;
  logic [NUM_REQ-1:0]          grant;
  logic                        grant_valid;
  logic [IDX_W-1:0]            grant_idx;

  // Requesting side: masters plus the fabric control that programs weights and mode
  modport master (
    output req, ack, weight, mode,
    input  grant, grant_valid, grant_idx
  );

  // Arbiter side
  modport slave (
    input  req, ack, weight, mode,
    output grant, grant_valid, grant_idx
  );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with a run-time fixed-priority mode.
// One requester holds the bus at a time, for up to weight+1 acked transfers.
// On release the next grant is chosen in the same cycle, so a handover
// leaves no idle bubble. Outputs come only from registers.
module wrr_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  wrr_arbiter_if.slave        bus,
  // Debug visibility of internal state
  output logic                state_o,
  output logic [IDX_W-1:0]    ptr_o,
  output logic [WEIGHT_W-1:0] credit_o
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;

  logic [WEIGHT_W-1:0] weight_arr [NUM_REQ];
  logic                cur_req;
  logic                release_c;
  logic [IDX_W-1:0]    ptr_rel;
  logic [IDX_W-1:0]    arb_start;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;

  // Unpack the flat weight bus into one field per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_weight
    assign weight_arr[g] = bus.weight[g*WEIGHT_W +: WEIGHT_W];
  end

  // Release decision and the pointer value a release would leave behind
  always_comb begin
    cur_req   = bus.req[idx_q];
    // Release on a final ack, or at once if the owner drops its request
    release_c = (state_q == S_GRANTED) &&
                (!cur_req || (bus.ack && (credit_q == '0)));
    ptr_rel   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    // A release re-arbitrates from the post-release pointer in the same cycle
    if (bus.mode) begin
      arb_start = '0;
    end else if (state_q == S_GRANTED) begin
      arb_start = ptr_rel;
    end else begin
      arb_start = ptr_q;
    end
  end

  // Ascending search from arb_start with wrap; the first set req bit wins
  always_comb begin
    int p;
    win_found = 1'b0;
    win_idx   = '0;
    p         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      p = int'(arb_start) + k;
      if (p >= NUM_REQ) begin
        p = p - NUM_REQ;
      end
      if (!win_found && bus.req[p]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(p);
      end
    end
  end

  // State register: grant, index, credit and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  // Next-state logic: grant, count down tenure, release and hand over
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        // ack is meaningless here and is ignored
        if (win_found) begin
          state_d          = S_GRANTED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          // Weight is captured only when the grant is issued
          credit_d         = weight_arr[win_idx];
        end
      end
      S_GRANTED: begin
        if (release_c) begin
          ptr_d = ptr_rel;
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            idx_d            = win_idx;
            credit_d         = weight_arr[win_idx];
          end else begin
            state_d  = S_IDLE;
            grant_d  = '0;
            idx_d    = '0;
            credit_d = '0;
          end
        end else if (bus.ack) begin
          // Not releasing with ack high implies credit is non-zero
          credit_d = credit_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs straight from registers; no path from req/ack to grant
  always_comb begin
    bus.grant       = grant_q;
    bus.grant_valid = |grant_q;
    bus.grant_idx   = idx_q;
    state_o         = state_q;
    ptr_o           = ptr_q;
    credit_o        = credit_q;
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (NUM_REQ=5, WEIGHT_W=4).
module tb_wrr_arbiter;
  localparam int N  = 5;
  localparam int W  = 4;
  localparam int IW = 3;

  logic clk;
  logic rst;
  logic            state_o;
  logic [IW-1:0]   ptr_o;
  logic [W-1:0]    credit_o;

  int tests_run;
  int tests_failed;

  // {valid, idx}
  logic [IW:0] exp_q[$];

  wrr_arbiter_if #(.NUM_REQ(N), .WEIGHT_W(W)) bus ();

  wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_o  (state_o),
    .ptr_o    (ptr_o),
    .credit_o (credit_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic expect_grant(input logic v, input int i);
    exp_q.push_back({v, IW'(i)});
  endtask

  // Advance one edge, sample 1 time unit later, compare against the queue head
  task automatic tick_check(input string tag);
    logic [IW:0]  e;
    logic [N-1:0] eg;
    @(posedge clk);
    #1;
    tests_run++;
    assert (exp_q.size() != 0) else begin
      tests_failed++;
      $error("FAIL %s scoreboard empty got idx=%0d exp entry", tag, bus.grant_idx);
    end
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      eg = '0;
      if (e[IW]) eg[e[IW-1:0]] = 1'b1;
      tests_run++;
      assert (bus.grant_valid === e[IW]) else begin
        tests_failed++;
        $error("FAIL %s grant_valid got %b exp %b", tag, bus.grant_valid, e[IW]);
      end
      tests_run++;
      assert (bus.grant_idx === e[IW-1:0]) else begin
        tests_failed++;
        $error("FAIL %s grant_idx got %0d exp %0d", tag, bus.grant_idx, e[IW-1:0]);
      end
      tests_run++;
      assert (bus.grant === eg) else begin
        tests_failed++;
        $error("FAIL %s grant got %b exp %b", tag, bus.grant, eg);
      end
    end
  endtask

  task automatic step(input logic v, input int i, input string tag);
    expect_grant(v, i);
    tick_check(tag);
  endtask

  task automatic check_val(input string tag, input int got, input int exp_v);
    tests_run++;
    assert (got === exp_v) else begin
      tests_failed++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp_v);
    end
  endtask

  // Directed sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.req      = 5'b11111;
    bus.ack      = 1'b0;
    bus.weight   = '0;
    bus.mode     = 1'b0;

    // Reset with all requesting
    step(1'b0, 0, "rst_c1");
    step(1'b0, 0, "rst_c2");
    check_val("rst_ptr", int'(ptr_o), 0);
    check_val("rst_credit", int'(credit_o), 0);
    rst = 1'b0;
    step(1'b1, 0, "first_grant");

    // Round-robin rotation, weights 0, ack every cycle
    bus.ack = 1'b1;
    step(1'b1, 1, "rr_1");
    step(1'b1, 2, "rr_2");
    step(1'b1, 3, "rr_3");
    step(1'b1, 4, "rr_4");
    step(1'b1, 0, "rr_wrap0");

    // Clean restart
    rst = 1'b1;
    bus.ack = 1'b0;
    step(1'b0, 0, "rst_b");
    rst = 1'b0;
    bus.req = '0;
    step(1'b0, 0, "idle_noreq");

    // Weighted tenure: weight[1]=2
    bus.weight = 20'h00020;
    bus.req    = 5'b00110;
    bus.ack    = 1'b1;
    step(1'b1, 1, "wt_a1");
    check_val("wt_credit_load", int'(credit_o), 2);
    step(1'b1, 1, "wt_a2");
    step(1'b1, 1, "wt_a3");
    check_val("wt_credit_zero", int'(credit_o), 0);
    step(1'b1, 2, "wt_b");
    step(1'b1, 1, "wt_c1");
    step(1'b1, 1, "wt_c2");
    step(1'b1, 1, "wt_c3");
    step(1'b1, 2, "wt_d");

    // Early drop of requester 3 with weight 7
    rst = 1'b1;
    bus.ack = 1'b0;
    step(1'b0, 0, "rst_c");
    rst = 1'b0;
    bus.req    = 5'b01000;
    bus.weight = 20'h07000;
    step(1'b1, 3, "drop_grant3");
    check_val("drop_credit7", int'(credit_o), 7);
    step(1'b1, 3, "drop_hold");
    check_val("drop_hold_credit", int'(credit_o), 7);
    bus.req = 5'b11000;
    step(1'b1, 3, "drop_hold2");
    bus.req = 5'b10000;
    step(1'b1, 4, "drop_to4");
    check_val("drop_ptr4", int'(ptr_o), 4);
    check_val("drop_credit4", int'(credit_o), 0);

    // Fixed priority
    rst = 1'b1;
    step(1'b0, 0, "rst_d");
    rst = 1'b0;
    bus.mode   = 1'b1;
    bus.weight = '0;
    bus.req    = 5'b10100;
    bus.ack    = 1'b1;
    step(1'b1, 2, "fp_1");
    step(1'b1, 2, "fp_2");
    step(1'b1, 2, "fp_3");
    bus.req = 5'b10000;
    step(1'b1, 4, "fp_drop");

    // Mid-operation reset and pointer wrap
    bus.mode = 1'b0;
    bus.ack  = 1'b0;
    step(1'b1, 4, "wrap_hold4");
    rst = 1'b1;
    step(1'b0, 0, "wrap_rst");
    check_val("wrap_rst_ptr", int'(ptr_o), 0);
    check_val("wrap_rst_state", int'(state_o), 0);
    rst = 1'b0;
    bus.req = 5'b10001;
    step(1'b1, 0, "wrap_g0");
    bus.ack = 1'b1;
    step(1'b1, 4, "wrap_g4");
    check_val("wrap_ptr1", int'(ptr_o), 1);
    step(1'b1, 0, "wrap_back0");
    check_val("wrap_ptr0", int'(ptr_o), 0);

    // Withdraw to idle, then ack while idle is ignored
    bus.ack = 1'b0;
    bus.req = '0;
    step(1'b0, 0, "withdraw_idle");
    check_val("withdraw_ptr", int'(ptr_o), 1);
    bus.ack = 1'b1;
    step(1'b0, 0, "idle_ack");
    check_val("idle_ack_ptr", int'(ptr_o), 1);

    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
